// File: rtl/serial_rx_buffer.sv
// serial_rx_buffer: reassembles MSB-first serial beats into parallel words,
// queues them in a first-word-fall-through FIFO with a valid/ready output,
// pulses a credit per popped word and keeps sticky framing/overflow flags.
module serial_rx_buffer #(
   parameter int SERIAL_WIDTH   = 4,
   parameter int PARALLEL_WIDTH = 32,
   parameter int DEPTH          = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         valid_in,
   input  logic [SERIAL_WIDTH-1:0]      sin,
   output logic [PARALLEL_WIDTH-1:0]    pout,
   output logic                         pvalid,
   input  logic                         pready,
   output logic                         credit,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         frame_err,
   output logic                         overflow,
   input  logic                         clear_err
);

   // Beats per frame; the last beat carries PAD filler bits below the word LSB.
   localparam int BEATS = (PARALLEL_WIDTH + SERIAL_WIDTH - 1) / SERIAL_WIDTH;
   localparam int PAD   = BEATS * SERIAL_WIDTH - PARALLEL_WIDTH;
   localparam int CTR_W = $clog2(BEATS + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic {S_IDLE, S_RECEIVE} state_t;

   state_t                    state_q, state_d;
   logic [CTR_W-1:0]          ctr_q, ctr_d;
   logic [PARALLEL_WIDTH-1:0] word_q, word_d;
   logic [CTR_W-1:0]          beat_idx;
   logic                      capture;
   logic                      push;
   logic                      truncate;

   logic [PARALLEL_WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0]          rd_ptr, wr_ptr;
   logic                      full;
   logic                      pop;
   logic                      accept;

   // Assembler next-state: which beat to capture, when to push, when a frame breaks.
   // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      ctr_d    = ctr_q;
      beat_idx = '0;
      capture  = 1'b0;
      push     = 1'b0;
      truncate = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_in) begin
               capture = 1'b1;
               if (BEATS == 1) begin
                  push = 1'b1;
               end else begin
                  ctr_d   = CTR_W'(1);
                  state_d = S_RECEIVE;
               end
            end
         end
         S_RECEIVE: begin
            if (valid_in) begin
               capture  = 1'b1;
               beat_idx = ctr_q;
               if (ctr_q == CTR_W'(BEATS - 1)) begin
                  push    = 1'b1;
                  ctr_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  ctr_d = ctr_q + CTR_W'(1);
               end
            end else begin
               truncate = 1'b1;
               ctr_d    = '0;
               state_d  = S_IDLE;
            end
         end
         default: begin
            ctr_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Word assembly: each word bit maps to one beat and one beat bit of the padded
   // frame; iterating over word bits keeps every write in range and drops the pad.
   // NOTE: combinational logic uses blocking '='; clocked state below uses '<=' only.
   always_comb begin
      word_d = word_q;
      for (int j = 0; j < PARALLEL_WIDTH; j++) begin
         if (capture && (beat_idx == CTR_W'(BEATS - 1 - (j + PAD) / SERIAL_WIDTH))) begin
            word_d[j] = sin[(j + PAD) % SERIAL_WIDTH];
         end
      end
   end

   // Assembler state register; reset discards any partial frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         ctr_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         word_q  <= word_d;
      end
   end

   // FIFO handshake: a push into a full FIFO is accepted only when a pop frees the slot.
   assign pvalid = (count != '0);
   assign full   = (count == CNT_W'(DEPTH));
   assign pop    = pvalid && pready;
   assign accept = push && (!full || pop);
   assign pout   = pvalid ? mem[rd_ptr] : '0;

   // FIFO storage write; the completed word is written on the last beat's edge.
   // NOTE: storage is deliberately not reset; count gates pout so stale data never shows.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= word_d;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
         case ({accept, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Credit pulse one cycle after each pop and sticky flags; a new event beats clear_err.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         credit    <= 1'b0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         credit    <= pop;
         frame_err <= (frame_err && !clear_err) || truncate;
         overflow  <= (overflow && !clear_err) || (push && !accept);
      end
   end

endmodule
